// File: rtl/debounce_pkg.sv
// Shared types and defaults for the debounce timer scheduler and its channel slices.
package debounce_pkg;

    typedef logic [0:0] cfg_state_t;
    localparam cfg_state_t CFG_IDLE = 1'b0;
    localparam cfg_state_t CFG_PEND = 1'b1;

    localparam int DEF_PRESCALE     = 1000;
    localparam int DEF_CNT_W        = 8;
    localparam int DEF_PERIOD_TICKS = 20;

    // A zero-tick period would make a reload expire without any wait, so it is promoted to one tick.
    function automatic logic [31:0] clamp_period(input logic [31:0] period);
        return (period == 32'd0) ? 32'd1 : period;
    endfunction

endpackage

// File: rtl/debounce_chan_timer.sv
// One debouncer channel slice: tick-driven down-counter plus edge capture into pending/overflow flags.
module debounce_chan_timer
    import debounce_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             tick,
    input  logic [CNT_W-1:0] period,
    input  logic             timer_reset,
    output logic             timer_done,
    input  logic             debounce_out,
    input  logic             evt_ack,
    output logic             evt_pending,
    output logic             evt_rise,
    output logic             evt_ovf
);

    logic [CNT_W-1:0] count_reg;
    logic             prev_reg;
    logic             edge_seen;

    assign edge_seen  = debounce_out ^ prev_reg;
    // Masking with timer_reset drops done in the very cycle the FSM requests a reload.
    assign timer_done = (count_reg == '0) && !timer_reset;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_reg   <= '0;
            prev_reg    <= 1'b0;
            evt_pending <= 1'b0;
            evt_rise    <= 1'b0;
            evt_ovf     <= 1'b0;
        end else begin
            if (timer_reset) begin
                count_reg <= period;
            end else if (tick && (count_reg != '0)) begin
                count_reg <= count_reg - CNT_W'(1);
            end

            prev_reg <= debounce_out;

            // A new edge wins over a simultaneous acknowledge so the event is never lost.
            if (edge_seen) begin
                evt_pending <= 1'b1;
                evt_rise    <= debounce_out;
            end else if (evt_ack) begin
                evt_pending <= 1'b0;
            end

            if (evt_ack) begin
                evt_ovf <= 1'b0;
            end else if (edge_seen && evt_pending) begin
                evt_ovf <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/debounce_timer_sched.sv
// Shared prescaler, run-time period register with valid/ready update, and event interrupt for N_CH debouncers.
module debounce_timer_sched
    import debounce_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int PRESCALE   = DEF_PRESCALE,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int DEF_PERIOD = DEF_PERIOD_TICKS
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_CH-1:0]  timer_reset,
    output logic [N_CH-1:0]  timer_done,
    input  logic [N_CH-1:0]  debounce_out,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_period,
    output logic             cfg_ready,
    input  logic [N_CH-1:0]  evt_ack,
    output logic [N_CH-1:0]  evt_pending,
    output logic [N_CH-1:0]  evt_rise,
    output logic [N_CH-1:0]  evt_ovf,
    output logic             irq
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PS_W-1:0]  presc_reg;
    logic             tick;
    logic [CNT_W-1:0] period_reg;
    logic [CNT_W-1:0] shadow_reg;
    cfg_state_t       cfg_state_reg;

    assign tick      = (presc_reg == PS_W'(PRESCALE - 1));
    assign cfg_ready = (cfg_state_reg == CFG_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_reg <= '0;
        end else if (tick) begin
            presc_reg <= '0;
        end else begin
            presc_reg <= presc_reg + PS_W'(1);
        end
    end

    // The period only changes on a tick, so every channel sees it switch at a tick boundary.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            period_reg    <= CNT_W'(DEF_PERIOD);
            shadow_reg    <= CNT_W'(DEF_PERIOD);
            cfg_state_reg <= CFG_IDLE;
        end else begin
            case (cfg_state_reg)
                CFG_IDLE: begin
                    if (cfg_valid) begin
                        shadow_reg    <= CNT_W'(clamp_period(32'(cfg_period)));
                        cfg_state_reg <= CFG_PEND;
                    end
                end
                CFG_PEND: begin
                    if (tick) begin
                        period_reg    <= shadow_reg;
                        cfg_state_reg <= CFG_IDLE;
                    end
                end
                default: cfg_state_reg <= CFG_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq <= 1'b0;
        end else begin
            irq <= |evt_pending;
        end
    end

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
            debounce_chan_timer #(
                .CNT_W(CNT_W)
            ) u_chan (
                .clk         (clk),
                .reset_n     (reset_n),
                .tick        (tick),
                .period      (period_reg),
                .timer_reset (timer_reset[gi]),
                .timer_done  (timer_done[gi]),
                .debounce_out(debounce_out[gi]),
                .evt_ack     (evt_ack[gi]),
                .evt_pending (evt_pending[gi]),
                .evt_rise    (evt_rise[gi]),
                .evt_ovf     (evt_ovf[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_debounce_timer_sched.sv
// Directed bench for debounce_timer_sched with PRESCALE=4, DEF_PERIOD=3; outputs sampled on the falling edge.
module tb_debounce_timer_sched;

    localparam int N_CH       = 4;
    localparam int PRESCALE   = 4;
    localparam int CNT_W      = 8;
    localparam int DEF_PERIOD = 3;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [N_CH-1:0]  timer_reset = '0;
    logic [N_CH-1:0]  timer_done;
    logic [N_CH-1:0]  debounce_out = '0;
    logic             cfg_valid = 1'b0;
    logic [CNT_W-1:0] cfg_period = '0;
    logic             cfg_ready;
    logic [N_CH-1:0]  evt_ack = '0;
    logic [N_CH-1:0]  evt_pending;
    logic [N_CH-1:0]  evt_rise;
    logic [N_CH-1:0]  evt_ovf;
    logic             irq;

    int errors = 0;
    int checks = 0;

    // Bench-side prescaler phase, used only to place stimulus relative to ticks.
    logic [1:0] m_presc;

    debounce_timer_sched #(
        .N_CH      (N_CH),
        .PRESCALE  (PRESCALE),
        .CNT_W     (CNT_W),
        .DEF_PERIOD(DEF_PERIOD)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .timer_reset (timer_reset),
        .timer_done  (timer_done),
        .debounce_out(debounce_out),
        .cfg_valid   (cfg_valid),
        .cfg_period  (cfg_period),
        .cfg_ready   (cfg_ready),
        .evt_ack     (evt_ack),
        .evt_pending (evt_pending),
        .evt_rise    (evt_rise),
        .evt_ovf     (evt_ovf),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) m_presc <= 2'd0;
        else          m_presc <= m_presc + 2'd1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_presc(input logic [1:0] v);
        for (int k = 0; k < 8; k++) begin
            if (m_presc == v) break;
            step();
        end
    endtask

    // Hold timer_reset[ch] for 'hold' cycles ending on a tick; returns on the first cycle after it.
    task automatic reload(input int ch, input int hold);
        wait_presc(2'(PRESCALE - hold));
        timer_reset[ch] = 1'b1;
        repeat (hold) step();
        timer_reset[ch] = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step();
        step();
        checks++; if (timer_done !== 4'hF) begin errors++; $display("FAIL reset_done: got %b want 1111", timer_done); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", cfg_ready); end
        checks++; if (evt_pending !== 4'h0) begin errors++; $display("FAIL reset_pending: got %b want 0000", evt_pending); end
        checks++; if (evt_rise !== 4'h0) begin errors++; $display("FAIL reset_rise: got %b want 0000", evt_rise); end
        checks++; if (evt_ovf !== 4'h0) begin errors++; $display("FAIL reset_ovf: got %b want 0000", evt_ovf); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irq); end
        reset_n = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_timer_basic();
        wait_presc(2'd2);
        timer_reset[0] = 1'b1;
        #1;
        checks++; if (timer_done[0] !== 1'b0) begin errors++; $display("FAIL basic_reset_mask: got %b want 0", timer_done[0]); end
        step();
        step();
        timer_reset[0] = 1'b0;
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (timer_done !== 4'b1110) begin
                errors++; $display("FAIL basic_count: cycle %0d timer_done=%b want 1110", i, timer_done);
            end
            step();
        end
        checks++; if (timer_done !== 4'b1111) begin errors++; $display("FAIL basic_expire: got %b want 1111", timer_done); end
        $display("test_timer_basic done");
    endtask

    task automatic test_reload_mid();
        reload(1, 2);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (timer_done[1] !== 1'b0) begin errors++; $display("FAIL mid_first: cycle %0d done=%b want 0", i, timer_done[1]); end
            step();
        end
        timer_reset[1] = 1'b1;
        #1;
        checks++; if (timer_done[1] !== 1'b0) begin errors++; $display("FAIL mid_pulse: got %b want 0", timer_done[1]); end
        step();
        timer_reset[1] = 1'b0;
        for (int j = 0; j < 11; j++) begin
            checks++;
            if (timer_done[1] !== 1'b0) begin errors++; $display("FAIL mid_second: cycle %0d done=%b want 0", j, timer_done[1]); end
            step();
        end
        checks++; if (timer_done[1] !== 1'b1) begin errors++; $display("FAIL mid_expire: got %b want 1", timer_done[1]); end
        $display("test_reload_mid done");
    endtask

    task automatic test_cfg_update();
        reload(0, 2);
        cfg_period = 8'd5;
        cfg_valid  = 1'b1;
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL cfg_ready_idle: got %b want 1", cfg_ready); end
        step();
        cfg_valid = 1'b0;
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL cfg_ready_pend: got %b want 0", cfg_ready); end
        step();
        step();
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL cfg_ready_tick: got %b want 0", cfg_ready); end
        step();
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL cfg_ready_back: got %b want 1", cfg_ready); end
        for (int i = 4; i < 12; i++) begin
            checks++;
            if (timer_done[0] !== 1'b0) begin errors++; $display("FAIL cfg_old_count: cycle %0d done=%b want 0", i, timer_done[0]); end
            step();
        end
        checks++; if (timer_done[0] !== 1'b1) begin errors++; $display("FAIL cfg_old_expire: got %b want 1", timer_done[0]); end
        reload(0, 1);
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (timer_done[0] !== 1'b0) begin errors++; $display("FAIL cfg_new_count: cycle %0d done=%b want 0", i, timer_done[0]); end
            step();
        end
        checks++; if (timer_done[0] !== 1'b1) begin errors++; $display("FAIL cfg_new_expire: got %b want 1", timer_done[0]); end
        $display("test_cfg_update done");
    endtask

    task automatic test_cfg_zero();
        wait_presc(2'd0);
        cfg_period = 8'd0;
        cfg_valid  = 1'b1;
        step();
        cfg_valid = 1'b0;
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL zero_pend: got %b want 0", cfg_ready); end
        step();
        step();
        // Reload lands on the update tick, so it must still use the old 5-tick period.
        timer_reset[1] = 1'b1;
        step();
        timer_reset[1] = 1'b0;
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL zero_back: got %b want 1", cfg_ready); end
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (timer_done[1] !== 1'b0) begin errors++; $display("FAIL zero_same_cycle: cycle %0d done=%b want 0", i, timer_done[1]); end
            step();
        end
        checks++; if (timer_done[1] !== 1'b1) begin errors++; $display("FAIL zero_same_expire: got %b want 1", timer_done[1]); end
        reload(3, 1);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (timer_done[3] !== 1'b0) begin errors++; $display("FAIL zero_count: cycle %0d done=%b want 0", i, timer_done[3]); end
            step();
        end
        checks++; if (timer_done[3] !== 1'b1) begin errors++; $display("FAIL zero_expire: got %b want 1", timer_done[3]); end
        $display("test_cfg_zero done");
    endtask

    task automatic test_events();
        debounce_out[2] = 1'b1;
        step();
        checks++; if (evt_pending[2] !== 1'b1) begin errors++; $display("FAIL evt_pend: got %b want 1", evt_pending[2]); end
        checks++; if (evt_rise[2] !== 1'b1) begin errors++; $display("FAIL evt_rise: got %b want 1", evt_rise[2]); end
        checks++; if (evt_ovf[2] !== 1'b0) begin errors++; $display("FAIL evt_no_ovf: got %b want 0", evt_ovf[2]); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL evt_irq_lag: got %b want 0", irq); end
        step();
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL evt_irq_set: got %b want 1", irq); end
        debounce_out[2] = 1'b0;
        step();
        checks++; if (evt_pending[2] !== 1'b1) begin errors++; $display("FAIL evt_pend2: got %b want 1", evt_pending[2]); end
        checks++; if (evt_rise[2] !== 1'b0) begin errors++; $display("FAIL evt_fall: got %b want 0", evt_rise[2]); end
        checks++; if (evt_ovf[2] !== 1'b1) begin errors++; $display("FAIL evt_ovf: got %b want 1", evt_ovf[2]); end
        evt_ack = 4'b0100;
        step();
        evt_ack = 4'b0000;
        checks++; if (evt_pending[2] !== 1'b0) begin errors++; $display("FAIL evt_ack_pend: got %b want 0", evt_pending[2]); end
        checks++; if (evt_ovf[2] !== 1'b0) begin errors++; $display("FAIL evt_ack_ovf: got %b want 0", evt_ovf[2]); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL evt_irq_hold: got %b want 1", irq); end
        step();
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL evt_irq_clear: got %b want 0", irq); end
        $display("test_events done");
    endtask

    task automatic test_edge_ack();
        debounce_out[3] = 1'b1;
        step();
        checks++; if (evt_pending[3] !== 1'b1) begin errors++; $display("FAIL ea_first: got %b want 1", evt_pending[3]); end
        debounce_out[3] = 1'b0;
        evt_ack[3] = 1'b1;
        step();
        evt_ack[3] = 1'b0;
        checks++; if (evt_pending[3] !== 1'b1) begin errors++; $display("FAIL ea_pend: got %b want 1", evt_pending[3]); end
        checks++; if (evt_rise[3] !== 1'b0) begin errors++; $display("FAIL ea_rise: got %b want 0", evt_rise[3]); end
        checks++; if (evt_ovf[3] !== 1'b0) begin errors++; $display("FAIL ea_ovf: got %b want 0", evt_ovf[3]); end
        evt_ack[0] = 1'b1;
        step();
        evt_ack[0] = 1'b0;
        checks++; if (evt_pending !== 4'b1000) begin errors++; $display("FAIL ea_idle_ack: got %b want 1000", evt_pending); end
        evt_ack[3] = 1'b1;
        step();
        evt_ack[3] = 1'b0;
        checks++; if (evt_pending !== 4'b0000) begin errors++; $display("FAIL ea_clear: got %b want 0000", evt_pending); end
        step();
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL ea_irq: got %b want 0", irq); end
        $display("test_edge_ack done");
    endtask

    task automatic test_async_reset();
        wait_presc(2'd0);
        debounce_out[1] = 1'b1;
        timer_reset[0]  = 1'b1;
        step();
        timer_reset[0] = 1'b0;
        cfg_period = 8'd7;
        cfg_valid  = 1'b1;
        step();
        cfg_valid = 1'b0;
        checks++; if (timer_done[0] !== 1'b0) begin errors++; $display("FAIL ar_pre_done: got %b want 0", timer_done[0]); end
        checks++; if (cfg_ready !== 1'b0) begin errors++; $display("FAIL ar_pre_ready: got %b want 0", cfg_ready); end
        checks++; if (evt_pending[1] !== 1'b1) begin errors++; $display("FAIL ar_pre_pend: got %b want 1", evt_pending[1]); end
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL ar_pre_irq: got %b want 1", irq); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (timer_done !== 4'hF) begin errors++; $display("FAIL ar_done: got %b want 1111", timer_done); end
        checks++; if (cfg_ready !== 1'b1) begin errors++; $display("FAIL ar_ready: got %b want 1", cfg_ready); end
        checks++; if (evt_pending !== 4'h0) begin errors++; $display("FAIL ar_pend: got %b want 0000", evt_pending); end
        checks++; if (evt_rise !== 4'h0) begin errors++; $display("FAIL ar_rise: got %b want 0000", evt_rise); end
        checks++; if (evt_ovf !== 4'h0) begin errors++; $display("FAIL ar_ovf: got %b want 0000", evt_ovf); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL ar_irq: got %b want 0", irq); end
        debounce_out = '0;
        step();
        reset_n = 1'b1;
        // Period must be back at the default of 3 ticks; the in-flight 7 is discarded.
        reload(0, 1);
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (timer_done[0] !== 1'b0) begin errors++; $display("FAIL ar_period_count: cycle %0d done=%b want 0", i, timer_done[0]); end
            step();
        end
        checks++; if (timer_done[0] !== 1'b1) begin errors++; $display("FAIL ar_period_expire: got %b want 1", timer_done[0]); end
        $display("test_async_reset done");
    endtask

    initial begin
        test_reset();
        test_timer_basic();
        test_reload_mid();
        test_cfg_update();
        test_cfg_zero();
        test_events();
        test_edge_ack();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
